// File: rtl/network_pkg.sv
// network_pkg: shared network constants, the encoder mode encoding and the
// spike-generator LFSR definition.
package network_pkg;

   localparam int PIXEL_WIDTH = 8;
   localparam int INPUT_SIZE  = 4;

   // Encoding mode, sampled together with each frame.
   typedef enum logic {
      ENC_RATE = 1'b0,   // stochastic: LFSR threshold comparison
      ENC_DET  = 1'b1    // deterministic: per-channel accumulator carry
   } enc_mode_e;

   // Fibonacci LFSR taps 16,14,13,11 expressed as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // One shift of the LFSR: feedback is the parity of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/snn_enc_lfsr.sv
// snn_enc_lfsr: 16-bit Fibonacci LFSR that shifts once per asserted adv.
module snn_enc_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] q
);
   import network_pkg::*;

   logic [15:0] r_lfsr;

   // Load the seed on reset, otherwise shift whenever a step completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= SEED;
      end else if (adv) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign q = r_lfsr;

endmodule

// File: rtl/snn_spike_encoder.sv
// snn_spike_encoder: turns one pixel frame into NUM_STEPS spike vectors using
// either LFSR rate coding or deterministic accumulator coding.
// Optional feature: define SNN_ENC_SPIKE_COUNT_EN to add the spike_count
// output (total spikes of the last completed frame).
module snn_spike_encoder #(
   parameter int          NUM_CH      = network_pkg::INPUT_SIZE,
   parameter int          PIXEL_WIDTH = network_pkg::PIXEL_WIDTH,
   parameter int          NUM_STEPS   = 16,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_CH*PIXEL_WIDTH-1:0]        pixel_in,
   input  logic                                 pixel_valid,
   output logic                                 pixel_ready,
   input  logic                                 enc_mode,
   output logic [NUM_CH-1:0]                    spike_out,
   output logic                                 spike_valid,
   input  logic                                 spike_ready,
   output logic [$clog2(NUM_STEPS)-1:0]         step_idx,
   output logic                                 frame_done
`ifdef SNN_ENC_SPIKE_COUNT_EN
   ,
   output logic [$clog2(NUM_CH*NUM_STEPS+1)-1:0] spike_count
`endif
);
   import network_pkg::*;

   localparam int            SW        = $clog2(NUM_STEPS);
   localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ENCODE = 1'b1;

   logic                          r_state;
   logic                          r_mode;
   logic [NUM_CH*PIXEL_WIDTH-1:0] r_pixels;
   // Holds the accumulator value *after* the current step, so the carry of
   // the current step is already sitting in r_spike.
   logic [NUM_CH*PIXEL_WIDTH-1:0] r_acc;
   logic [NUM_CH-1:0]             r_spike;
   logic [SW-1:0]                 r_step;

   logic                          w_last;
   logic                          w_step_done;
   logic                          w_ready;
   logic                          w_accept;
   logic [15:0]                   w_lfsr_q;
   logic [PIXEL_WIDTH-1:0]        w_rand;
   logic [NUM_CH-1:0]             w_spike_first;
   logic [NUM_CH-1:0]             w_spike_next;
   logic [NUM_CH*PIXEL_WIDTH-1:0] w_acc_next;

   snn_enc_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk (clk),
      .rst (rst),
      .adv (w_step_done),
      .q   (w_lfsr_q)
   );

   assign w_last      = (r_step == LAST_STEP);
   assign w_step_done = (r_state == ST_ENCODE) && spike_ready;
   assign w_ready     = (r_state == ST_IDLE) || (w_last && spike_ready);
   assign w_accept    = pixel_valid && w_ready;

   // The registered spike vector is for the *next* step, whose LFSR value is
   // the post-shift one whenever a step is completing this cycle.
   assign w_rand = w_step_done ? PIXEL_WIDTH'(lfsr_next(w_lfsr_q))
                               : w_lfsr_q[PIXEL_WIDTH-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam logic [PIXEL_WIDTH-1:0] CH_ID = PIXEL_WIDTH'(gi);
         logic [PIXEL_WIDTH-1:0] w_pix_new;
         logic [PIXEL_WIDTH-1:0] w_pix_cur;
         logic [PIXEL_WIDTH-1:0] w_acc_cur;
         logic [PIXEL_WIDTH:0]   w_sum;

         assign w_pix_new = pixel_in[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
         assign w_pix_cur = r_pixels[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
         assign w_acc_cur = r_acc[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
         assign w_sum     = {1'b0, w_acc_cur} + {1'b0, w_pix_cur};
         assign w_acc_next[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = w_sum[PIXEL_WIDTH-1:0];

         // Step 0 of a new frame: the cleared accumulator can never carry.
         assign w_spike_first[gi] = (enc_mode == ENC_DET) ? 1'b0
                                  : (w_pix_new > (w_rand ^ CH_ID));
         assign w_spike_next[gi]  = (r_mode == ENC_DET) ? w_sum[PIXEL_WIDTH]
                                  : (w_pix_cur > (w_rand ^ CH_ID));
      end
   endgenerate

   // Frame accept, step sequencing and registered spike generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_mode   <= 1'b0;
         r_pixels <= '0;
         r_acc    <= '0;
         r_spike  <= '0;
         r_step   <= '0;
      end else if (w_accept) begin
         // Covers both a fresh start and the zero-bubble hand-over.
         r_state  <= ST_ENCODE;
         r_mode   <= enc_mode;
         r_pixels <= pixel_in;
         r_acc    <= pixel_in;   // 0 + pixel, carry already known to be 0
         r_spike  <= w_spike_first;
         r_step   <= '0;
      end else if (w_step_done) begin
         if (w_last) begin
            r_state <= ST_IDLE;
            r_spike <= '0;
            r_step  <= '0;
         end else begin
            r_acc   <= w_acc_next;
            r_spike <= w_spike_next;
            r_step  <= r_step + 1'b1;
         end
      end
   end

`ifdef SNN_ENC_SPIKE_COUNT_EN
   localparam int CW = $clog2(NUM_CH*NUM_STEPS+1);
   logic [CW-1:0] r_run_count;
   logic [CW-1:0] r_spike_count;
   logic [CW-1:0] w_run_sum;

   assign w_run_sum = r_run_count + CW'($countones(r_spike));

   // Running spike total; published and restarted when the final step completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_run_count   <= '0;
         r_spike_count <= '0;
      end else if (w_step_done) begin
         if (w_last) begin
            r_spike_count <= w_run_sum;
            r_run_count   <= '0;
         end else begin
            r_run_count   <= w_run_sum;
         end
      end
   end

   assign spike_count = r_spike_count;
`endif

   assign pixel_ready = w_ready;
   assign spike_out   = r_spike;
   assign spike_valid = (r_state == ST_ENCODE);
   assign step_idx    = r_step;
   assign frame_done  = (r_state == ST_ENCODE) && w_last;

endmodule

// File: doc/snn_spike_encoder.md
SNN_SPIKE_ENCODER -- requirements
Module: snn_spike_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default INPUT_SIZE, number of pixel/spike channels.
REQ-002 SHALL have parameter PIXEL_WIDTH, default PIXEL_WIDTH (package), bits per pixel.
REQ-003 SHALL have parameter NUM_STEPS, default 16, timesteps per frame (>=2).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 SHALL have the following ports, and no others:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- pixel_in  input  NUM_CH*PIXEL_WIDTH  flattened frame; channel c at [c*PIXEL_WIDTH +: PIXEL_WIDTH].
- pixel_valid  input  1  frame offered.
- pixel_ready  output  1  frame can be accepted.
- enc_mode  input  1  0 = rate (LFSR), 1 = deterministic (accumulator); sampled at frame accept.
- spike_out  output  NUM_CH  spikes for current step.
- spike_valid  output  1  spike_out valid.
- spike_ready  input  1  consumer accepts step.
- step_idx  output  $clog2(NUM_STEPS)  index of current step.
- frame_done  output  1  high with the final step's spike_valid.
- spike_count  output  $clog2(NUM_CH*NUM_STEPS+1)  total spikes of last completed frame (macro only, REQ-020).

Function
REQ-006 SHALL have states IDLE and ENCODE.
REQ-007 Frame accept SHALL occur when pixel_valid && pixel_ready; pixel_in and enc_mode are latched into a frame register; step_idx is set to 0; all accumulators are cleared.
REQ-008 pixel_ready SHALL be 1 in IDLE, and in ENCODE only when step_idx==NUM_STEPS-1 && spike_ready; it SHALL be 0 otherwise.
REQ-009 spike_valid SHALL rise the cycle after accept and SHALL stay high throughout ENCODE.
REQ-010 A step SHALL complete on spike_valid && spike_ready; step_idx then increments, and the LFSR/accumulators advance.
REQ-011 While spike_ready=0, spike_out, step_idx, frame_done and all state SHALL hold stable.
REQ-012 On completion of step NUM_STEPS-1: with a simultaneous frame accept, the block SHALL stay in ENCODE at step 0 with the new frame (zero-bubble); otherwise it SHALL go to IDLE with spike_valid=0.
REQ-013 Deterministic mode: per channel, sum = acc + pixel (PIXEL_WIDTH+1 bits); spike = sum carry bit; acc <= low PIXEL_WIDTH bits, updated on step completion.
REQ-014 Rate mode: one 16-bit Fibonacci LFSR (taps 16,14,13,11); spike[c] = pixel[c] > (lfsr[PIXEL_WIDTH-1:0] ^ c[PIXEL_WIDTH-1:0]); the LFSR advances once per step completion and is not reset between frames.
REQ-015 Pixel 0 SHALL never spike in either mode.
REQ-016 spike_out SHALL be registered state (not a combinational path from pixel_in); in IDLE it SHALL be 0.

Reset
REQ-017 On rst: state=IDLE, spike_out=0, spike_valid=0, step_idx=0, frame_done=0, accumulators=0, lfsr=LFSR_SEED, spike_count=0.
REQ-018 rst during ENCODE SHALL abort the frame with no further spike_valid; pixel_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-019 Macro SNN_ENC_SPIKE_COUNT_EN SHALL select the spike-count feature.
REQ-020 With the macro defined: the block SHALL sum popcount(spike_out) over completed steps; spike_count SHALL update to the frame total the cycle after the final step completes and hold until the next frame finishes.
REQ-021 Without the macro: the spike_count port SHALL be absent, with no counter logic.

Structure
REQ-022 PIXEL_WIDTH, INPUT_SIZE, the enc_mode encoding enum and the LFSR tap constant SHALL reside in network_pkg.
REQ-023 The LFSR SHALL be sub-module snn_enc_lfsr (ports clk, rst, adv, q[15:0]).

Verification
REQ-024 Deterministic, all pixels=128, spike_ready=1 -> spikes on odd steps 1..15 only; 8 per channel; frame_done on step 15.
REQ-025 Deterministic, ch0=255, ch1=64, ch2=0 -> 15, 4 (steps 3,7,11,15) and 0 spikes respectively; with the macro defined, spike_count=19 for NUM_CH=3.
REQ-026 spike_ready toggled 0/1 every cycle -> identical spike sequence to REQ-024; outputs stable while stalled; 32 cycles per frame.
REQ-027 Two frames back-to-back with pixel_valid held high -> second frame's step 0 follows the first frame's step 15 with no spike_valid gap.
REQ-028 Rate mode, pixels=255, fixed seed -> spike_out matches reference-model LFSR comparison each step; pixel 0 channels silent.
REQ-029 rst asserted at step 7 -> spike_valid=0 the next cycle, all outputs at reset values, and a new frame is accepted normally.
